// File: rtl/nrzi_dec.sv
// rtl/nrzi_dec.sv - NRZI line decoder with sync-word hunt and framed byte output
// Optional feature macro: NRZI_DEC_UNSTUFF_EN (drops the stuff bit after five decoded 1s in payload)
module nrzi_dec #(
    parameter logic [7:0] SYNC_WORD   = 8'hD5,
    parameter int         FRAME_BYTES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       din,
    input  logic       din_en,
    output logic [7:0] dout,
    output logic       dout_valid,
    output logic       sync_det,
    output logic       frame_end,
    output logic       err
);

    typedef enum logic {
        HUNT    = 1'b0,
        PAYLOAD = 1'b1
    } state_t;

    // Index of the final byte of a frame; byte_cnt counts completed bytes.
    localparam logic [7:0] LAST_BYTE = 8'(FRAME_BYTES - 1);

    state_t     state_q, state_d;
    logic       prev_q;
    logic [7:0] window_q, window_d;
    logic [7:0] shreg_q, shreg_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] byte_cnt_q, byte_cnt_d;
    logic [7:0] dout_d;
    logic       dout_valid_d;
    logic       sync_det_d;
    logic       frame_end_d;

    logic       dec_bit;
    logic [7:0] window_shift;
    logic [7:0] byte_shift;
    logic       take_data;

`ifdef NRZI_DEC_UNSTUFF_EN
    logic [2:0] run_q, run_d;
    logic       err_q, err_d;
`endif

    // A line toggle between consecutive consumed bits decodes as 1.
    assign dec_bit      = din ^ prev_q;
    assign window_shift = {window_q[6:0], dec_bit};
    assign byte_shift   = {shreg_q[6:0], dec_bit};

    // Next-state and pulse decode; nothing moves on cycles without din_en.
    always_comb begin
        state_d      = state_q;
        window_d     = window_q;
        shreg_d      = shreg_q;
        bit_cnt_d    = bit_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        dout_d       = dout;
        dout_valid_d = 1'b0;
        sync_det_d   = 1'b0;
        frame_end_d  = 1'b0;
        take_data    = 1'b0;
`ifdef NRZI_DEC_UNSTUFF_EN
        run_d        = run_q;
        err_d        = 1'b0;
`endif
        if (din_en) begin
            case (state_q)
                HUNT: begin
                    window_d = window_shift;
`ifdef NRZI_DEC_UNSTUFF_EN
                    run_d    = 3'd0;
`endif
                    if (window_shift == SYNC_WORD) begin
                        state_d    = PAYLOAD;
                        bit_cnt_d  = 3'd0;
                        byte_cnt_d = 8'd0;
                        sync_det_d = 1'b1;
                    end
                end
                PAYLOAD: begin
`ifdef NRZI_DEC_UNSTUFF_EN
                    if (run_q == 3'd5) begin
                        // This bit is a stuff bit: never data, and a 1 here is illegal.
                        run_d = 3'd0;
                        if (dec_bit) begin
                            err_d    = 1'b1;
                            state_d  = HUNT;
                            window_d = 8'h00;
                        end
                    end else begin
                        run_d     = dec_bit ? run_q + 3'd1 : 3'd0;
                        take_data = 1'b1;
                    end
`else
                    take_data = 1'b1;
`endif
                end
                default: begin
                    state_d = HUNT;
                end
            endcase

            if (take_data) begin
                shreg_d   = byte_shift;
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    dout_d       = byte_shift;
                    dout_valid_d = 1'b1;
                    if (byte_cnt_q == LAST_BYTE) begin
                        frame_end_d = 1'b1;
                        state_d     = HUNT;
                        window_d    = 8'h00;
                        byte_cnt_d  = 8'd0;
`ifdef NRZI_DEC_UNSTUFF_EN
                        run_d       = 3'd0;
`endif
                    end else begin
                        byte_cnt_d = byte_cnt_q + 8'd1;
                    end
                end
            end
        end
    end

    // State, line history and registered one-cycle pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= HUNT;
            prev_q     <= 1'b0;
            window_q   <= 8'h00;
            shreg_q    <= 8'h00;
            bit_cnt_q  <= 3'd0;
            byte_cnt_q <= 8'd0;
            dout       <= 8'h00;
            dout_valid <= 1'b0;
            sync_det   <= 1'b0;
            frame_end  <= 1'b0;
        end else begin
            if (din_en) begin
                prev_q <= din;
            end
            state_q    <= state_d;
            window_q   <= window_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            dout       <= dout_d;
            dout_valid <= dout_valid_d;
            sync_det   <= sync_det_d;
            frame_end  <= frame_end_d;
        end
    end

`ifdef NRZI_DEC_UNSTUFF_EN
    // Consecutive-1 run tracking and the stuffing-violation pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= 3'd0;
            err_q <= 1'b0;
        end else begin
            run_q <= run_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_nrzi_dec.sv
// tb/tb_nrzi_dec.sv - self-checking bench for nrzi_dec against a behavioural decoder model
module tb_nrzi_dec;

    localparam logic [7:0] SYNC = 8'hD5;
    localparam int         FB   = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       din;
    logic       din_en;
    logic [7:0] dout;
    logic       dout_valid;
    logic       sync_det;
    logic       frame_end;
    logic       err;

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model state
    bit         m_prev;
    bit         m_in_frame;
    int         m_win;
    int         m_byte;
    int         m_nbits;
    int         m_nbytes;
    int         m_run;
    logic [7:0] e_dout;
    bit         e_dv, e_sync, e_fe, e_err;

    // Transmit-side encoder state and observation logs
    bit         line_lvl;
    int         tx_run;
    logic [7:0] sent[$];
    logic [7:0] got[$];
    int         sync_count;
    int         err_count;
    int         fe_count;

    nrzi_dec #(.SYNC_WORD(SYNC), .FRAME_BYTES(FB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_en     (din_en),
        .dout       (dout),
        .dout_valid (dout_valid),
        .sync_det   (sync_det),
        .frame_end  (frame_end),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_prev = 0; m_in_frame = 0; m_win = 0; m_byte = 0;
        m_nbits = 0; m_nbytes = 0; m_run = 0;
        e_dout = 8'h00; e_dv = 0; e_sync = 0; e_fe = 0; e_err = 0;
        line_lvl = 0; tx_run = 0;
    endtask

    // One clock edge of the decoder's rules, applied to integer state.
    task automatic model_edge(input bit d, input bit en);
        bit b;
        bit is_data;
        e_dv = 0; e_sync = 0; e_fe = 0; e_err = 0;
        if (!en) return;
        b = d ^ m_prev;
        m_prev = d;
        if (!m_in_frame) begin
            m_win = (m_win * 2 + b) % 256;
            if (m_win == SYNC) begin
                m_in_frame = 1; m_nbits = 0; m_nbytes = 0; m_run = 0; e_sync = 1;
            end
            return;
        end
        is_data = 1;
`ifdef NRZI_DEC_UNSTUFF_EN
        if (m_run == 5) begin
            is_data = 0;
            m_run = 0;
            if (b) begin
                e_err = 1; m_in_frame = 0; m_win = 0;
            end
        end else begin
            m_run = b ? m_run + 1 : 0;
        end
`endif
        if (is_data) begin
            m_byte = (m_byte * 2 + b) % 256;
            m_nbits++;
            if (m_nbits == 8) begin
                m_nbits = 0;
                e_dout = m_byte[7:0];
                e_dv = 1;
                m_nbytes++;
                if (m_nbytes == FB) begin
                    e_fe = 1; m_in_frame = 0; m_win = 0; m_run = 0;
                end
            end
        end
    endtask

    task automatic check_all();
        chk("dout", dout, e_dout);
        chk("dout_valid", {7'b0, dout_valid}, {7'b0, e_dv});
        chk("sync_det", {7'b0, sync_det}, {7'b0, e_sync});
        chk("frame_end", {7'b0, frame_end}, {7'b0, e_fe});
        chk("err", {7'b0, err}, {7'b0, e_err});
    endtask

    task automatic step(input bit d, input bit en);
        @(negedge clk);
        din = d;
        din_en = en;
        @(posedge clk);
        model_edge(d, en);
        #1;
        check_all();
        if (dout_valid) got.push_back(dout);
        if (sync_det) sync_count++;
        if (err) err_count++;
        if (frame_end) fe_count++;
    endtask

    task automatic send_bit(input bit b);
        line_lvl = line_lvl ^ b;
        step(line_lvl, 1'b1);
    endtask

    // din carries random junk while disabled; the decoder must ignore it.
    task automatic idle();
        step(1'($urandom), 1'b0);
    endtask

    task automatic send_data_bit(input bit b);
`ifdef NRZI_DEC_UNSTUFF_EN
        if (tx_run == 5) begin
            send_bit(1'b0);
            tx_run = 0;
        end
        tx_run = b ? tx_run + 1 : 0;
`endif
        send_bit(b);
    endtask

    task automatic send_sync();
        logic [7:0] s;
        s = SYNC;
        tx_run = 0;
        for (int i = 7; i >= 0; i--) send_bit(s[i]);
    endtask

    // gap_mode: 0 back-to-back, 1 strict din_en toggling, 2 random idles
    task automatic send_byte(input logic [7:0] v, input int gap_mode);
        for (int i = 7; i >= 0; i--) begin
            if (gap_mode == 1) idle();
            else if (gap_mode == 2 && $urandom_range(0, 2) == 0) idle();
            send_data_bit(v[i]);
        end
    endtask

    task automatic compare_logs(input string tag);
        chk({tag, "_count"}, 8'(got.size()), 8'(sent.size()));
        for (int i = 0; i < sent.size() && i < got.size(); i++)
            chk(tag, got[i], sent[i]);
        got.delete();
        sent.delete();
    endtask

    task automatic async_reset();
        @(posedge clk);
        #3 rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        #2 rst_n = 1'b1;
    endtask

    initial begin
        int sc;
        int fc;
        logic [7:0] v;
        rst_n = 1'b0; din = 1'b0; din_en = 1'b0;
        sync_count = 0; err_count = 0; fe_count = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Line 1,0,0,1,1,0,0,1 decodes to D5: exactly one sync_det
        send_sync();
        chk("sync_once", 8'(sync_count), 8'd1);

        // Fixed frame, back to back
        sent = '{8'h3C, 8'hA5, 8'h00, 8'hFF};
        for (int k = 0; k < FB; k++) send_byte(sent[k], 0);
        compare_logs("fixed_frame");
        chk("fe_fixed", 8'(fe_count), 8'd1);

        // Same frame with din_en toggling every cycle
        send_sync();
        sent = '{8'h3C, 8'hA5, 8'h00, 8'hFF};
        for (int k = 0; k < FB; k++) send_byte(sent[k], 1);
        compare_logs("toggle_frame");
        chk("fe_toggle", 8'(fe_count), 8'd2);

        // Random frames; a payload byte equal to SYNC is data, not a sync
        for (int f = 0; f < 6; f++) begin
            sc = sync_count;
            send_sync();
            for (int k = 0; k < FB; k++) begin
                v = (f == 2 && k == 1) ? SYNC : 8'($urandom);
                sent.push_back(v);
                send_byte(v, (f % 2 == 1) ? 2 : 0);
            end
            chk("rand_sync", 8'(sync_count), 8'(sc + 1));
            compare_logs("rand_frame");
        end

        // Constant line in HUNT decodes to zeros: no sync ever
        sc = sync_count;
        repeat (40) step(line_lvl, 1'b1);
        chk("const_line", 8'(sync_count), 8'(sc));

        // Reset after 3 payload bits discards the frame
        send_sync();
        send_data_bit(1'b1); send_data_bit(1'b0); send_data_bit(1'b1);
        async_reset();
        fc = fe_count;
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        repeat (24) send_bit(1'b0);
        chk("rst_no_dv", 8'(got.size()), 8'd0);
        chk("rst_no_fe", 8'(fe_count), 8'(fc));
        got.delete();
        send_sync();
        sent = '{8'h12, 8'h34, 8'h56, 8'h78};
        for (int k = 0; k < FB; k++) send_byte(sent[k], 0);
        compare_logs("post_rst_frame");

`ifdef NRZI_DEC_UNSTUFF_EN
        // Stuff bit 0 is dropped: 1,1,1,1,1,(0),1,1,1 -> FF, no err
        send_sync();
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        chk("stuff_ok_dout", got.size() > 0 ? got[0] : 8'hxx, 8'hFF);
        chk("stuff_ok_err", 8'(err_count), 8'd0);
        got.delete();
        async_reset();
        // Stuff bit 1 is a violation: err and return to HUNT
        send_sync();
        for (int i = 0; i < 6; i++) send_bit(1'b1);
        chk("stuff_bad_err", 8'(err_count), 8'd1);
        chk("stuff_bad_dv", 8'(got.size()), 8'd0);
        repeat (8) send_bit(1'b0);
        send_sync();
        sent = '{8'hFF, 8'hF8, 8'h7E, 8'h01};
        for (int k = 0; k < FB; k++) send_byte(sent[k], 2);
        compare_logs("post_err_frame");
`endif

        // Random line noise with random enables, model-checked each edge
        for (int i = 0; i < 400; i++) step(1'($urandom), 1'($urandom));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/nrzi_dec.md
NRZI_DEC -- requirements
Module: nrzi_dec

Interface
REQ-001 SHALL provide parameter SYNC_WORD, default 8'hD5, the decoded sync pattern that opens a frame, compared MSB-first.
REQ-002 SHALL provide parameter FRAME_BYTES, default 4, the payload bytes per frame; legal range 1..255.
REQ-003 SHALL provide port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL provide port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL provide port din  input  1  toggle-encoded (NRZI) line input; a line toggle encodes 1, no toggle encodes 0.
REQ-006 SHALL provide port din_en  input  1  qualifies din; one line bit is consumed per clk with din_en=1.
REQ-007 SHALL provide port dout  output  8  last decoded payload byte, first-received bit in dout[7].
REQ-008 SHALL provide port dout_valid  output  1  one-cycle pulse marking a new dout.
REQ-009 SHALL provide port sync_det  output  1  one-cycle pulse when SYNC_WORD is matched.
REQ-010 SHALL provide port frame_end  output  1  one-cycle pulse coincident with dout_valid for the last byte of a frame.
REQ-011 SHALL provide port err  output  1  one-cycle pulse on a stuffing violation; tied 0 when the stuffing feature is compiled out.

Function
REQ-012 Decoded bit SHALL be b = din XOR prev, where prev is the last consumed line bit; prev updates only on cycles with din_en=1.
REQ-013 Cycles with din_en=0 SHALL leave all state unchanged and drive all pulses low.
REQ-014 FSM states SHALL be HUNT and PAYLOAD.
REQ-015 HUNT: each b shifts into an 8-bit window (new bit at LSB); when the updated window equals SYNC_WORD, go to PAYLOAD, clear the bit and byte counters, and pulse sync_det the next cycle.
REQ-016 PAYLOAD: each accepted b shifts into the byte register; on the 8th bit, dout loads the byte and dout_valid pulses the cycle after the din_en cycle carrying that bit (latency 1 clk).
REQ-017 After byte number FRAME_BYTES, frame_end SHALL pulse with dout_valid, the FSM SHALL return to HUNT, and the window SHALL be cleared to 8'h00.
REQ-018 Sync matching SHALL NOT occur in PAYLOAD; payload bytes equal to SYNC_WORD are delivered as data.
REQ-019 dout SHALL hold its value between dout_valid pulses.
REQ-020 A line held constant forever in HUNT SHALL decode to all-zero and never match a nonzero SYNC_WORD.

Reset
REQ-021 On rst_n=0, immediately and regardless of clk: state=HUNT, prev=0, window=8'h00, counters=0, dout=8'h00, dout_valid=sync_det=frame_end=err=0.
REQ-022 Reset mid-frame SHALL discard the partial byte and frame; no dout_valid or frame_end follows deassertion until a new sync.

Configuration
REQ-023 With macro NRZI_DEC_UNSTUFF_EN defined: in PAYLOAD, after five consecutive decoded 1s, the next decoded bit is a stuff bit and is not counted or shifted; if it is 0, the run count clears; if it is 1, err pulses the next cycle, the FSM returns to HUNT, and the window clears.
REQ-024 The consecutive-1 run counter SHALL clear on any decoded 0, on sync_det, and on return to HUNT.
REQ-025 Without NRZI_DEC_UNSTUFF_EN, every PAYLOAD bit is data, no run counter exists, and err is constant 0.

Verification
REQ-026 Reset, then din_en=1 with din=1,0,0,1,1,0,0,1 (decodes to 8'hD5) -> sync_det pulses once, one cycle after the 8th bit.
REQ-027 After the sync in REQ-026, the line for payload 8'h3C,8'hA5,8'h00,8'hFF (stuffing off) -> four dout_valid pulses with those values, frame_end on the 4th, then HUNT.
REQ-028 din_en toggled 0/1 every cycle during the REQ-027 stream -> identical dout sequence; no pulses on din_en=0 cycles.
REQ-029 rst_n pulsed low after 3 payload bits -> outputs cleared at once; the remaining bits produce no dout_valid; a fresh sync is then required.
REQ-030 NRZI_DEC_UNSTUFF_EN defined, payload bits 1,1,1,1,1,0(stuff),1,1,1 -> dout=8'hFF with no err; repeat with stuff bit 1 -> err pulse and return to HUNT.
